// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter for the proc core bus.
// Three word registers (TXDATA, STATUS, DIVISOR) sit at BASE_ADDR..BASE_ADDR+2.
// Bytes written to TXDATA are queued in a small FIFO and sent LSB first on txd.
// Read data is registered, so a read has the same one-cycle latency as memory.
module uart_tx_mmio #(
    parameter logic [15:0] BASE_ADDR  = 16'h0010,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        W,
    input  logic [15:0] realaddr,
    input  logic [31:0] dout,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        txd,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // A divisor of zero would stall the bit timer, so it is clamped to one.
    function automatic logic [15:0] sat_div(input logic [15:0] value);
        return (value == 16'd0) ? 16'd1 : value;
    endfunction

    // Bus decode
    logic [15:0] offset;
    logic        in_window;
    logic        wr_txdata;
    logic        wr_status;
    logic        wr_divisor;

    // FIFO
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           empty;
    logic           full;
    logic           push;
    logic           pop;

    // Control / status registers
    logic        overflow;
    logic [15:0] div_reg;

    // Transmitter
    tx_state_t   state_q;
    tx_state_t   state_d;
    logic [7:0]  shift_q;
    logic [15:0] div_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic        bit_end;
    logic        busy;

    // Read path
    logic [31:0] rd_mux;

    // The upper half of the write data has no destination in this block.
    logic unused_dout;
    assign unused_dout = ^dout[31:16];

    assign offset     = realaddr - BASE_ADDR;
    assign in_window  = (offset < 16'd3);
    assign wr_txdata  = W && (offset == 16'd0);
    assign wr_status  = W && (offset == 16'd1);
    assign wr_divisor = W && (offset == 16'd2);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign pop     = (state_q == ST_IDLE) && !empty;
    assign push    = wr_txdata && (!full || pop);
    assign bit_end = (cnt_q == 16'd0);
    assign irq     = empty && (state_q == ST_IDLE);

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= dout[7:0];
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky overflow flag and baud divisor register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
            div_reg  <= DIV_RESET;
        end else begin
            if (wr_txdata && full && !pop) begin
                overflow <= 1'b1;
            end else if (wr_status && dout[3]) begin
                overflow <= 1'b0;
            end
            if (wr_divisor) begin
                div_reg <= sat_div(dout[15:0]);
            end
        end
    end

    // Transmitter state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transmitter next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!empty)                         state_d = ST_START;
            ST_START: if (bit_end)                        state_d = ST_DATA;
            ST_DATA:  if (bit_end && bit_idx_q == 3'd7)   state_d = ST_STOP;
            ST_STOP:  if (bit_end)                        state_d = ST_IDLE;
            default:                                      state_d = ST_IDLE;
        endcase
    end

    // Transmitter outputs: line level and busy flag.
    always_comb begin
        txd  = 1'b1;
        busy = 1'b1;
        case (state_q)
            ST_IDLE:  busy = 1'b0;
            ST_START: txd  = 1'b0;
            ST_DATA:  txd  = shift_q[0];
            ST_STOP:  txd  = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    // Bit timer, shift register and bit index; the divisor is frozen per frame in div_q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q   <= 8'd0;
            div_q     <= DIV_RESET;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        shift_q <= fifo_mem[rd_ptr[PTR_W-1:0]];
                        div_q   <= div_reg;
                        cnt_q   <= div_reg - 16'd1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt_q     <= div_q - 16'd1;
                        bit_idx_q <= 3'd0;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q     <= div_q - 16'd1;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (!bit_end) begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: cnt_q <= 16'd0;
            endcase
        end
    end

    // Register read mux; reflects state before any same-cycle write lands.
    always_comb begin
        rd_mux = 32'd0;
        case (offset[1:0])
            2'd1:    rd_mux = {28'd0, overflow, busy, empty, full};
            2'd2:    rd_mux = {16'd0, div_reg};
            default: rd_mux = 32'd0;
        endcase
    end

    // Registered read data and hit flag, independent of W.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= 32'd0;
            hit   <= 1'b0;
        end else begin
            hit   <= in_window;
            rdata <= in_window ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio.
module tb_uart_tx_mmio;

    localparam logic [15:0] BASE = 16'h0010;
    localparam logic [15:0] IDLE_ADDR = 16'h0000;

    logic        clk;
    logic        resetn;
    logic        W;
    logic [15:0] realaddr;
    logic [31:0] dout;
    logic [31:0] rdata;
    logic        hit;
    logic        txd;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .DIV_RESET  (16'd434)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .W        (W),
        .realaddr (realaddr),
        .dout     (dout),
        .rdata    (rdata),
        .hit      (hit),
        .txd      (txd),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level for bit slot i of an 8N1 frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        W = 1'b1; realaddr = a; dout = d;
        tick();
        W = 1'b0; realaddr = IDLE_ADDR; dout = 32'd0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic h);
        W = 1'b0; realaddr = a;
        tick();
        d = rdata; h = hit;
        realaddr = IDLE_ADDR;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        h;
        n_checks++; if (txd !== 1'b1) $display("FAIL reset_txd got %b want 1", txd); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL reset_irq got %b want 1", irq); else n_pass++;
        n_checks++; if (hit !== 1'b0) $display("FAIL reset_hit got %b want 0", hit); else n_pass++;
        n_checks++; if (rdata !== 32'd0) $display("FAIL reset_rdata got %h want 0", rdata); else n_pass++;
        #9 resetn = 1'b1;
        // start a frame, then pull reset in the middle of its start bit
        bus_write(BASE, 32'h0000_0000);
        tick();
        n_checks++; if (txd !== 1'b0) $display("FAIL midrun_start_bit got %b want 0", txd); else n_pass++;
        realaddr = BASE + 16'd1;
        tick();
        realaddr = IDLE_ADDR;
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (txd !== 1'b1) $display("FAIL midrun_reset_txd got %b want 1", txd); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL midrun_reset_irq got %b want 1", irq); else n_pass++;
        n_checks++; if (hit !== 1'b0) $display("FAIL midrun_reset_hit got %b want 0", hit); else n_pass++;
        #2 resetn = 1'b1;
        bus_read(BASE + 16'd1, d, h);
        n_checks++; if (d !== 32'h2) $display("FAIL reset_status got %h want 2", d); else n_pass++;
        bus_read(BASE + 16'd2, d, h);
        n_checks++; if (d !== 32'd434) $display("FAIL reset_divisor got %0d want 434", d); else n_pass++;
        n_checks++; if (txd !== 1'b1) $display("FAIL reset_frame_abandoned got %b want 1", txd); else n_pass++;
    endtask

    task automatic test_single_frame();
        bus_write(BASE + 16'd2, 32'd4);
        bus_write(BASE, 32'h55);
        n_checks++; if (txd !== 1'b1) $display("FAIL frame55_pre txd got %b want 1", txd); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL frame55_irq_pre got %b want 0", irq); else n_pass++;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_checks++;
            if (txd !== frame_bit(8'h55, (k - 1) / 4))
                $display("FAIL frame55_txd cycle %0d got %b want %b", k, txd, frame_bit(8'h55, (k - 1) / 4));
            else n_pass++;
            if (k == 20) begin
                n_checks++; if (irq !== 1'b0) $display("FAIL frame55_irq_mid got %b want 0", irq); else n_pass++;
            end
        end
        tick();
        n_checks++; if (txd !== 1'b1) $display("FAIL frame55_post txd got %b want 1", txd); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL frame55_irq_post got %b want 1", irq); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        h;
        logic        exp;
        int          u;
        int          f;
        int          k;
        for (int t = 0; t <= 206; t++) begin
            if (t < 6) begin
                W = 1'b1; realaddr = BASE; dout = 32'h41 + t;
            end else if (t == 6) begin
                W = 1'b0; realaddr = BASE + 16'd1; dout = 32'd0;
            end else begin
                W = 1'b0; realaddr = IDLE_ADDR; dout = 32'd0;
            end
            tick();
            exp = 1'b1;
            if (t >= 1) begin
                u = t - 1; f = u / 41; k = u % 41;
                if (f < 5 && k < 40) exp = frame_bit(8'h41 + f[7:0], k / 4);
            end
            n_checks++;
            if (txd !== exp) $display("FAIL burst_txd cycle %0d got %b want %b", t, txd, exp);
            else n_pass++;
            if (t == 6) begin
                n_checks++; if (rdata !== 32'hD) $display("FAIL burst_status got %h want d", rdata); else n_pass++;
                n_checks++; if (hit !== 1'b1) $display("FAIL burst_status_hit got %b want 1", hit); else n_pass++;
            end
        end
        bus_read(BASE + 16'd1, d, h);
        n_checks++; if (d !== 32'hA) $display("FAIL burst_drained_status got %h want a", d); else n_pass++;
        bus_write(BASE + 16'd1, 32'h8);
        bus_read(BASE + 16'd1, d, h);
        n_checks++; if (d !== 32'h2) $display("FAIL overflow_clear got %h want 2", d); else n_pass++;
    endtask

    task automatic test_div_zero();
        logic [31:0] d;
        logic        h;
        bus_write(BASE + 16'd2, 32'd0);
        bus_read(BASE + 16'd2, d, h);
        n_checks++; if (d !== 32'd1) $display("FAIL div_zero_read got %0d want 1", d); else n_pass++;
        bus_write(BASE, 32'hA5);
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (txd !== frame_bit(8'hA5, k - 1))
                $display("FAIL frameA5_txd cycle %0d got %b want %b", k, txd, frame_bit(8'hA5, k - 1));
            else n_pass++;
        end
        tick();
        n_checks++; if (txd !== 1'b1) $display("FAIL frameA5_post txd got %b want 1", txd); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL frameA5_irq_post got %b want 1", irq); else n_pass++;
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic        h;
        bus_read(BASE + 16'd3, d, h);
        n_checks++; if (h !== 1'b0) $display("FAIL decode_plus3_hit got %b want 0", h); else n_pass++;
        n_checks++; if (d !== 32'd0) $display("FAIL decode_plus3_rdata got %h want 0", d); else n_pass++;
        bus_read(16'h000F, d, h);
        n_checks++; if (h !== 1'b0) $display("FAIL decode_0f_hit got %b want 0", h); else n_pass++;
        n_checks++; if (d !== 32'd0) $display("FAIL decode_0f_rdata got %h want 0", d); else n_pass++;
        bus_write(BASE + 16'd3, 32'h0000_0055);
        bus_write(16'h000F, 32'h0000_0007);
        tick();
        n_checks++; if (txd !== 1'b1) $display("FAIL decode_no_tx txd got %b want 1", txd); else n_pass++;
        bus_read(BASE + 16'd2, d, h);
        n_checks++; if (d !== 32'd1) $display("FAIL decode_div_kept got %0d want 1", d); else n_pass++;
        tick();
        realaddr = BASE + 16'd1;
        #2;
        n_checks++; if (hit !== 1'b0) $display("FAIL decode_hit_early got %b want 0", hit); else n_pass++;
        tick();
        n_checks++; if (hit !== 1'b1) $display("FAIL decode_status_hit got %b want 1", hit); else n_pass++;
        n_checks++; if (rdata !== 32'h2) $display("FAIL decode_status_rdata got %h want 2", rdata); else n_pass++;
        realaddr = IDLE_ADDR;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d;
        logic        h;
        bus_write(BASE + 16'd2, 32'd4);
        for (int i = 0; i < 5; i++) bus_write(BASE, 32'h11 + i);
        repeat (36) tick();
        bus_read(BASE + 16'd1, d, h);
        n_checks++; if (d !== 32'h5) $display("FAIL full_before_status got %h want 5", d); else n_pass++;
        bus_write(BASE, 32'h16);
        bus_read(BASE + 16'd1, d, h);
        n_checks++; if (d !== 32'h5) $display("FAIL full_pushpop_status got %h want 5", d); else n_pass++;
        bus_write(BASE, 32'h17);
        bus_read(BASE + 16'd1, d, h);
        n_checks++; if (d !== 32'hD) $display("FAIL full_overflow_status got %h want d", d); else n_pass++;
    endtask

    initial begin
        resetn   = 1'b0;
        W        = 1'b0;
        realaddr = IDLE_ADDR;
        dout     = 32'd0;
        #3;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_div_zero();
        test_decode();
        test_full_push_pop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
